// File: rtl/crc4_serial_checker_if.sv
// Serial framed-bit link into the CRC-4 checker plus its result outputs.
interface crc4_serial_checker_if #(
    parameter int DATA_W = 64
) ();
    logic              bit_in;
    logic              bit_valid;
    logic              frame_start;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        crc_rx;
    logic [3:0]        crc_calc;
    logic              crc_ok;
    logic              frame_valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_in, bit_valid, frame_start,
        input  data_out, crc_rx, crc_calc, crc_ok, frame_valid, frame_err, busy
    );

    modport slave (
        input  bit_in, bit_valid, frame_start,
        output data_out, crc_rx, crc_calc, crc_ok, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/crc4_serial_checker.sv
// Deserialises DATA_W data bits + 4 CRC bits (MSB first), checks CRC-4 and reports per frame.
// state  | meaning
// IDLE   | waiting for bit_valid & frame_start
// DATA   | shifting data bits and stepping the CRC
// CRC    | collecting the 4 received CRC bits
module crc4_serial_checker #(
    parameter int         DATA_W = 64,
    parameter logic [3:0] POLY   = 4'b0011,
    parameter logic [3:0] INIT   = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crc4_serial_checker_if.slave  sio
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CRC
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        crc_q, crc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [3:0]        crx_q, crx_d;
    logic [3:0]        ccalc_q, ccalc_d;
    logic              ok_q, ok_d;
    logic              fv_q, fv_d;
    logic              ferr_q, ferr_d;
    logic [3:0]        rx_shift;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = b ^ c[3];
        return {c[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);
    endfunction

    assign rx_shift = {rx_q[2:0], sio.bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= INIT;
            shift_q <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            crx_q   <= '0;
            ccalc_q <= '0;
            ok_q    <= 1'b0;
            fv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            crx_q   <= crx_d;
            ccalc_q <= ccalc_d;
            ok_q    <= ok_d;
            fv_q    <= fv_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        crx_d   = crx_q;
        ccalc_d = ccalc_q;
        ok_d    = ok_q;
        fv_d    = 1'b0;
        ferr_d  = 1'b0;

        if (sio.bit_valid) begin
            // A start bit always wins, even on the last CRC bit: the old frame is dropped.
            if (sio.frame_start) begin
                ferr_d  = (state_q != S_IDLE);
                state_d = S_DATA;
                cnt_d   = CNT_W'(1);
                crc_d   = crc_step(INIT, sio.bit_in);
                shift_d = {{(DATA_W-1){1'b0}}, sio.bit_in};
                rx_d    = '0;
            end else begin
                case (state_q)
                    S_DATA: begin
                        shift_d = {shift_q[DATA_W-2:0], sio.bit_in};
                        crc_d   = crc_step(crc_q, sio.bit_in);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = S_CRC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_CRC: begin
                        rx_d = rx_shift;
                        if (cnt_q == CNT_W'(3)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            dout_d  = shift_q;
                            crx_d   = rx_shift;
                            ccalc_d = crc_q;
                            ok_d    = (rx_shift == crc_q);
                            fv_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sio.data_out    = dout_q;
    assign sio.crc_rx      = crx_q;
    assign sio.crc_calc    = ccalc_q;
    assign sio.crc_ok      = ok_q;
    assign sio.frame_valid = fv_q;
    assign sio.frame_err   = ferr_q;
    assign sio.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_crc4_serial_checker.sv
// Randomized frame stimulus for crc4_serial_checker, checked against a polynomial-division model.
module tb_crc4_serial_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    crc4_serial_checker_if #(.DATA_W(64)) sio ();

    crc4_serial_checker #(.DATA_W(64), .POLY(4'b0011), .INIT(4'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sio   (sio)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  rx;
        logic [3:0]  calc;
        logic        ok;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vcnt = 0;
    int   fv_count = 0;
    int   ferr_count = 0;
    int   fv_cyc = 0;
    int   fv_vcnt_last = 0;
    int   fv_vcnt_prev = 0;
    int   start_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Remainder of data * x^4 divided by x^4+x+1, by long division.
    function automatic logic [3:0] crc_ref(input logic [63:0] d);
        logic [67:0] r;
        r = {d, 4'b0000};
        for (int i = 67; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (sio.bit_valid) vcnt++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sio.frame_valid) begin
                exp_t e;
                fv_count++;
                fv_cyc       = cyc;
                fv_vcnt_prev = fv_vcnt_last;
                fv_vcnt_last = vcnt;
                chk("fv_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data_out", sio.data_out, e.d);
                    chk("crc_rx", 64'(sio.crc_rx), 64'(e.rx));
                    chk("crc_calc", 64'(sio.crc_calc), 64'(e.calc));
                    chk("crc_ok", 64'(sio.crc_ok), 64'(e.ok));
                end
            end
            if (sio.frame_err) ferr_count++;
        end
    end

    task automatic put(input logic v, input logic s, input logic b);
        sio.bit_valid   = v;
        sio.frame_start = s;
        sio.bit_in      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) put(1'b0, 1'b0, 1'b0);
    endtask

    // Sends bits 0..67, or only 0..abort_at-1 when abort_at >= 0 (next start aborts it).
    task automatic send_frame(input logic [63:0] d, input logic [3:0] c,
                              input int gap_pct, input int abort_at);
        logic busy_bad;
        logic b;
        exp_t e;
        busy_bad = 1'b0;
        for (int i = 0; i < 68; i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                chk("busy_in_frame", 64'(busy_bad), 64'd0);
                return;
            end
            while (int'($urandom_range(99)) < gap_pct) begin
                put(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                if (i > 0 && sio.busy !== 1'b1) busy_bad = 1'b1;
            end
            b = (i < 64) ? d[63-i] : c[67-i];
            if (i == 67) begin
                e.d    = d;
                e.rx   = c;
                e.calc = crc_ref(d);
                e.ok   = (c == crc_ref(d));
                exp_q.push_back(e);
            end
            if (i == 0) start_cyc = cyc;
            put(1'b1, i == 0, b);
            if (i < 67 && sio.busy !== 1'b1) busy_bad = 1'b1;
        end
        chk("busy_in_frame", 64'(busy_bad), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, sio.data_out, 64'd0);
        chk({tag, "_crc_rx"}, 64'(sio.crc_rx), 64'd0);
        chk({tag, "_crc_calc"}, 64'(sio.crc_calc), 64'd0);
        chk({tag, "_crc_ok"}, 64'(sio.crc_ok), 64'd0);
        chk({tag, "_fv"}, 64'(sio.frame_valid), 64'd0);
        chk({tag, "_ferr"}, 64'(sio.frame_err), 64'd0);
        chk({tag, "_busy"}, 64'(sio.busy), 64'd0);
    endtask

    initial begin
        int fv0, fe0;
        logic [63:0] d;
        logic [3:0]  c;
        logic        bad;

        sio.bit_in = 1'b0;
        sio.bit_valid = 1'b0;
        sio.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Test 1: all-zero frame, latency 68 cycles from start bit.
        send_frame(64'd0, 4'h0, 0, -1);
        idle(2);
        chk("t1_latency", 64'(fv_cyc - start_cyc), 64'd68);
        chk("t1_ok", 64'(sio.crc_ok), 64'd1);
        chk("t1_data", sio.data_out, 64'd0);

        // Test 2: data 1 with matching and mismatching CRC.
        send_frame(64'd1, 4'b0011, 0, -1);
        idle(2);
        chk("t2a_calc", 64'(sio.crc_calc), 64'h3);
        chk("t2a_ok", 64'(sio.crc_ok), 64'd1);
        send_frame(64'd1, 4'b0010, 0, -1);
        idle(2);
        chk("t2b_ok", 64'(sio.crc_ok), 64'd0);
        chk("t2b_rx", 64'(sio.crc_rx), 64'h2);

        // Test 3: MSB-only data, no gaps then with gaps.
        send_frame(64'h8000_0000_0000_0000, 4'b1011, 0, -1);
        idle(2);
        chk("t3a_calc", 64'(sio.crc_calc), 64'hB);
        chk("t3a_ok", 64'(sio.crc_ok), 64'd1);
        send_frame(64'h8000_0000_0000_0000, 4'b1011, 40, -1);
        idle(2);
        chk("t3b_calc", 64'(sio.crc_calc), 64'hB);
        chk("t3b_msb", 64'(sio.data_out[63]), 64'd1);

        // Test 4: abort at data bit 30; results must hold until B completes.
        fv0 = fv_count; fe0 = ferr_count;
        send_frame({$urandom, $urandom}, 4'($urandom), 10, 30);
        send_frame(64'd0, 4'h0, 0, -1);
        idle(2);
        chk("t4_ferr_pulses", 64'(ferr_count - fe0), 64'd1);
        chk("t4_fv_pulses", 64'(fv_count - fv0), 64'd1);
        chk("t4_ok", 64'(sio.crc_ok), 64'd1);

        // Abort on the cycle of CRC bit 3: old frame must not report, result outputs hold.
        fv0 = fv_count; fe0 = ferr_count;
        send_frame({$urandom, $urandom}, 4'($urandom), 0, 67);
        send_frame(64'h0123_4567_89AB_CDEF, crc_ref(64'h0123_4567_89AB_CDEF), 0, 10);
        chk("t4c_hold_data", sio.data_out, 64'd0);
        send_frame(64'h0123_4567_89AB_CDEF, crc_ref(64'h0123_4567_89AB_CDEF), 0, -1);
        idle(2);
        chk("t4c_ferr_pulses", 64'(ferr_count - fe0), 64'd2);
        chk("t4c_fv_pulses", 64'(fv_count - fv0), 64'd1);

        // Test 5: back-to-back frames, second with gaps.
        fv0 = fv_count;
        d = {$urandom, $urandom};
        send_frame(d, crc_ref(d), 0, -1);
        d = {$urandom, $urandom};
        send_frame(d, crc_ref(d), 25, -1);
        idle(2);
        chk("t5_fv_pulses", 64'(fv_count - fv0), 64'd2);
        chk("t5_spacing", 64'(fv_vcnt_last - fv_vcnt_prev), 64'd68);

        // Test 6: async reset during CRC bits.
        d = 64'hFFFF_0000_A5A5_5A5A;
        send_frame(d, 4'hF, 0, 66);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            put(1'b1, 1'b0, 1'($urandom_range(1)));
            if (sio.busy !== 1'b0 || sio.frame_valid !== 1'b0) bad = 1'b1;
        end
        chk("t6_stray_ignored", 64'(bad), 64'd0);
        send_frame(d, crc_ref(d), 0, -1);
        idle(2);
        chk("t6_after_ok", 64'(sio.crc_ok), 64'd1);

        // Random frames: random data, good or corrupted CRC, random gaps.
        for (int n = 0; n < 25; n++) begin
            d = {$urandom, $urandom};
            c = crc_ref(d);
            if ($urandom_range(1) == 1) c = c ^ 4'($urandom_range(15, 1));
            send_frame(d, c, int'($urandom_range(30)), -1);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(4, 1)));
        end
        idle(3);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
